// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: MIPS opcode/funct/REGIMM constants, FSM states and datapath select encodings
package mips_ctrl_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, MULDIV, WB, HALT} state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;
  localparam logic [5:0] F_JR = 6'h08, F_JALR = 6'h09, F_MTHI = 6'h11, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;
  localparam logic [4:0] RI_BLTZ = 5'h00, RI_BGEZ = 5'h01, RI_BLTZAL = 5'h10, RI_BGEZAL = 5'h11;
  localparam logic [1:0] ALU_ADD = 2'd0, ALU_CMP = 2'd1, ALU_FUNCT = 2'd2, ALU_ILOGIC = 2'd3;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_LINK = 2'd2;
endpackage

// File: rtl/multicycle_control_decode.sv
// instr_decode: combinational instruction classification and datapath selects from IR fields
module instr_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] function_code,
  input  logic [4:0] b_code,
  output logic       is_load,
  output logic       is_store,
  output logic       is_muldiv,
  output logic       is_branch,
  output logic       is_jump,
  output logic       writes_reg,
  output logic       wr_hi,
  output logic       wr_lo,
  output logic       alu_src,
  output logic       rd_select,
  output logic       imdt_sel,
  output logic [1:0] alu_op,
  output logic [1:0] wb_sel
);
  logic rtype, regimm, link, imm_logic, imm_alu;
  always_comb begin
    rtype      = opcode == OP_RTYPE;
    regimm     = opcode == OP_REGIMM;
    is_load    = opcode inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    is_store   = opcode inside {OP_SB, OP_SH, OP_SW};
    is_muldiv  = rtype && function_code inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
    is_branch  = opcode inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ} ||
                 (regimm && b_code inside {RI_BLTZ, RI_BGEZ, RI_BLTZAL, RI_BGEZAL});
    is_jump    = opcode inside {OP_J, OP_JAL} || (rtype && function_code inside {F_JR, F_JALR});
    link       = opcode == OP_JAL || (rtype && function_code == F_JALR) ||
                 (regimm && b_code inside {RI_BLTZAL, RI_BGEZAL});
    imm_logic  = opcode inside {OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
    imm_alu    = imm_logic || opcode inside {OP_ADDI, OP_ADDIU};
    wr_hi      = rtype && function_code == F_MTHI;
    wr_lo      = rtype && function_code == F_MTLO;
    writes_reg = link || is_load || imm_alu ||
                 (rtype && !is_muldiv && !wr_hi && !wr_lo && function_code != F_JR);
    alu_op     = rtype ? ALU_FUNCT : is_branch ? ALU_CMP : imm_logic ? ALU_ILOGIC : ALU_ADD;
    alu_src    = imm_alu || is_load || is_store;
    rd_select  = rtype;
    imdt_sel   = opcode inside {OP_ANDI, OP_ORI, OP_XORI};
    wb_sel     = link ? WB_LINK : is_load ? WB_MEM : WB_ALU;
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM with memory stalls, MULT/DIV busy period and delay slots
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] function_code,
  input  logic [4:0] b_code,
  input  logic       mem_waitrequest,
  input  logic       branch_taken,
  input  logic       jump_target_zero,
  output logic [2:0] state,
  output logic       active,
  output logic       ir_load,
  output logic       pc_write,
  output logic       pc_redirect,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       hi_wren,
  output logic       lo_wren,
  output logic       muldiv_start,
  output logic       muldiv_busy,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic       rd_select,
  output logic       imdt_sel,
  output logic [1:0] wb_sel
);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);
  state_t st, nx;
  logic [CNT_W-1:0] cnt;
  logic slot, slot_zero, pend, pend_zero, taken, sel_v;
  logic d_load, d_store, d_muldiv, d_branch, d_jump, d_wreg, d_hi, d_lo, d_src, d_rd, d_imdt;
  logic [1:0] d_alu, d_wb;
  instr_decode u_dec (
    .opcode(opcode), .function_code(function_code), .b_code(b_code),
    .is_load(d_load), .is_store(d_store), .is_muldiv(d_muldiv), .is_branch(d_branch),
    .is_jump(d_jump), .writes_reg(d_wreg), .wr_hi(d_hi), .wr_lo(d_lo), .alu_src(d_src),
    .rd_select(d_rd), .imdt_sel(d_imdt), .alu_op(d_alu), .wb_sel(d_wb)
  );
  assign taken = d_branch ? branch_taken : d_jump;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st        <= FETCH;
      cnt       <= '0;
      slot      <= 1'b0;
      slot_zero <= 1'b0;
      pend      <= 1'b0;
      pend_zero <= 1'b0;
    end else begin
      st  <= nx;
      cnt <= (st == EXEC && d_muldiv) ? (function_code inside {F_DIV, F_DIVU} ? DIV_LD : MUL_LD) :
             (st == MULDIV && cnt != '0) ? cnt - 1'b1 : cnt;
      if (st == EXEC) begin
        pend      <= taken;
        pend_zero <= taken && jump_target_zero;
      end
      // the flag retiring here belongs to the instruction now in the slot
      if (st == WB) begin
        slot      <= pend;
        slot_zero <= pend_zero;
        pend      <= 1'b0;
        pend_zero <= 1'b0;
      end
    end
  always_comb begin
    nx = st;
    case (st)
      FETCH:   nx = mem_waitrequest ? FETCH : DECODE;
      DECODE:  nx = EXEC;
      EXEC:    nx = (d_load || d_store) ? MEM : d_muldiv ? MULDIV : WB;
      MEM:     nx = mem_waitrequest ? MEM : WB;
      MULDIV:  nx = cnt == '0 ? WB : MULDIV;
      WB:      nx = (slot && slot_zero) ? HALT : FETCH;
      default: nx = HALT;
    endcase
  end
  assign sel_v        = st inside {DECODE, EXEC, MEM, MULDIV, WB};
  assign state        = st;
  assign active       = st != HALT;
  assign ir_load      = st == FETCH && !mem_waitrequest;
  assign pc_write     = st == WB;
  assign pc_redirect  = st == WB && slot;
  assign mem_read     = st == FETCH || (st == MEM && d_load);
  assign mem_write    = st == MEM && d_store;
  assign reg_write    = st == WB && d_wreg;
  assign hi_wren      = (st == MULDIV && cnt == '0) || (st == WB && d_hi);
  assign lo_wren      = (st == MULDIV && cnt == '0) || (st == WB && d_lo);
  assign muldiv_start = st == EXEC && d_muldiv;
  assign muldiv_busy  = st == MULDIV;
  assign alu_op       = sel_v ? d_alu : 2'd0;
  assign alu_src      = sel_v && d_src;
  assign rd_select    = sel_v && d_rd;
  assign imdt_sel     = sel_v && d_imdt;
  assign wb_sel       = sel_v ? d_wb : 2'd0;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed instruction sequences with per-instruction strobe counts
module tb_multicycle_control;
  import mips_ctrl_pkg::*;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [5:0] opcode = '0, function_code = '0;
  logic [4:0] b_code = '0;
  logic mem_waitrequest = 1'b0, branch_taken = 1'b0, jump_target_zero = 1'b0;
  logic [2:0] state;
  logic active, ir_load, pc_write, pc_redirect, mem_read, mem_write, reg_write;
  logic hi_wren, lo_wren, muldiv_start, muldiv_busy, alu_src, rd_select, imdt_sel;
  logic [1:0] alu_op, wb_sel;
  int passed = 0, total = 0;
  int cyc, n_rw, n_pw, n_rd, n_irl, n_mrd, n_mwr, n_busy, n_hi, n_lo, n_start, n_redir, wbs;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .function_code(function_code), .b_code(b_code),
    .mem_waitrequest(mem_waitrequest), .branch_taken(branch_taken),
    .jump_target_zero(jump_target_zero), .state(state), .active(active), .ir_load(ir_load),
    .pc_write(pc_write), .pc_redirect(pc_redirect), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .hi_wren(hi_wren), .lo_wren(lo_wren), .muldiv_start(muldiv_start),
    .muldiv_busy(muldiv_busy), .alu_op(alu_op), .alu_src(alu_src), .rd_select(rd_select),
    .imdt_sel(imdt_sel), .wb_sel(wb_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // run one instruction from FETCH to the edge after its WB, counting strobes
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] bc,
                     input logic tk, input logic tz, input int fw, input int mw);
    int fc = 0, wc = 0;
    logic seen_wb = 1'b0;
    opcode = op; function_code = fn; b_code = bc; branch_taken = tk; jump_target_zero = tz;
    cyc = 0; n_rw = 0; n_pw = 0; n_rd = 0; n_irl = 0; n_mrd = 0; n_mwr = 0; n_busy = 0;
    n_hi = 0; n_lo = 0; n_start = 0; n_redir = 0; wbs = -1;
    while (!seen_wb && cyc <= 100) begin
      mem_waitrequest = (state == FETCH && fc < fw) || (state == MEM && wc < mw);
      if (state == FETCH && mem_waitrequest) fc++;
      if (state == MEM && mem_waitrequest) wc++;
      #1;
      cyc++;
      n_rw += int'(reg_write); n_pw += int'(pc_write); n_rd += int'(mem_read);
      n_irl += int'(ir_load); n_mwr += int'(mem_write); n_busy += int'(muldiv_busy);
      n_hi += int'(hi_wren); n_lo += int'(lo_wren); n_start += int'(muldiv_start);
      if (state == MEM) n_mrd += int'(mem_read);
      if (state == WB) begin
        seen_wb = 1'b1;
        wbs = int'(wb_sel);
        n_redir = int'(pc_redirect);
      end
      step();
    end
    mem_waitrequest = 1'b0;
    chk("cycle_bound", int'(cyc > 100), 0);
  endtask

  initial begin
    int n_halt_strobe;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", int'(state), int'(FETCH));
    chk("rst_active", int'(active), 1);
    chk("rst_strobes", int'({pc_write, pc_redirect, mem_write, reg_write, hi_wren, lo_wren,
                             muldiv_start, muldiv_busy}), 0);
    chk("rst_selects", int'({alu_op, alu_src, rd_select, imdt_sel, wb_sel}), 0);
    step();
    rst_n = 1'b1;

    run(OP_RTYPE, 6'h21, 5'd0, 1'b0, 1'b0, 0, 0);
    chk("addu_cycles", cyc, 4);
    chk("addu_regwr", n_rw, 1);
    chk("addu_pcwr", n_pw, 1);
    chk("addu_irload", n_irl, 1);
    chk("addu_state", int'(state), int'(FETCH));

    run(OP_RTYPE, 6'h21, 5'd0, 1'b0, 1'b0, 2, 0);
    chk("fetchwait_cycles", cyc, 6);
    chk("fetchwait_irload", n_irl, 1);

    run(OP_LW, 6'h00, 5'd0, 1'b0, 1'b0, 0, 3);
    chk("lw_cycles", cyc, 8);
    chk("lw_memrd_mem", n_mrd, 4);
    chk("lw_regwr", n_rw, 1);
    chk("lw_wbsel", wbs, 1);

    run(OP_SW, 6'h00, 5'd0, 1'b0, 1'b0, 0, 1);
    chk("sw_memwr", n_mwr, 2);
    chk("sw_regwr", n_rw, 0);

    run(OP_RTYPE, F_DIVU, 5'd0, 1'b0, 1'b0, 0, 0);
    chk("divu_cycles", cyc, 36);
    chk("divu_busy", n_busy, 32);
    chk("divu_hi", n_hi, 1);
    chk("divu_lo", n_lo, 1);
    chk("divu_start", n_start, 1);
    chk("divu_regwr", n_rw, 0);

    run(OP_RTYPE, F_MULTU, 5'd0, 1'b0, 1'b0, 0, 0);
    chk("multu_busy", n_busy, 4);
    chk("multu_cycles", cyc, 8);

    run(OP_RTYPE, F_MTHI, 5'd0, 1'b0, 1'b0, 0, 0);
    chk("mthi_hi_lo_rw", n_hi * 100 + n_lo * 10 + n_rw, 100);

    run(OP_BEQ, 6'h00, 5'd0, 1'b1, 1'b0, 0, 0);
    chk("beq_redir", n_redir, 0);
    chk("beq_regwr", n_rw, 0);
    run(OP_ADDIU, 6'h00, 5'd0, 1'b0, 1'b0, 0, 0);
    chk("slot_redir", n_redir, 1);
    chk("slot_regwr", n_rw, 1);
    run(OP_RTYPE, 6'h21, 5'd0, 1'b0, 1'b0, 0, 0);
    chk("after_slot_redir", n_redir, 0);

    run(OP_BEQ, 6'h00, 5'd0, 1'b0, 1'b0, 0, 0);
    run(OP_RTYPE, 6'h21, 5'd0, 1'b0, 1'b0, 0, 0);
    chk("nottaken_slot_redir", n_redir, 0);

    run(OP_REGIMM, 6'h00, RI_BGEZAL, 1'b1, 1'b0, 0, 0);
    chk("bgezal_regwr", n_rw, 1);
    chk("bgezal_wbsel", wbs, 2);
    run(OP_BNE, 6'h00, 5'd0, 1'b1, 1'b0, 0, 0);
    chk("branch_in_slot_redir", n_redir, 1);
    run(OP_RTYPE, 6'h21, 5'd0, 1'b0, 1'b0, 0, 0);
    chk("second_slot_redir", n_redir, 1);
    run(OP_RTYPE, 6'h21, 5'd0, 1'b0, 1'b0, 0, 0);
    chk("post_chain_redir", n_redir, 0);

    run(OP_RTYPE, F_JR, 5'd0, 1'b0, 1'b1, 0, 0);
    chk("jr_regwr", n_rw, 0);
    chk("jr_state", int'(state), int'(FETCH));
    run(OP_RTYPE, 6'h00, 5'd0, 1'b0, 1'b0, 0, 0);
    chk("nop_slot_redir", n_redir, 1);
    chk("halt_state", int'(state), int'(HALT));
    chk("halt_active", int'(active), 0);
    n_halt_strobe = 0;
    for (int i = 0; i < 6; i++) begin
      mem_waitrequest = i[0];
      #1;
      n_halt_strobe += int'(mem_read) + int'(pc_write) + int'(ir_load) + int'(reg_write);
      step();
    end
    mem_waitrequest = 1'b0;
    chk("halt_strobes", n_halt_strobe, 0);
    chk("halt_stays", int'(state), int'(HALT));

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("halt_rst_state", int'(state), int'(FETCH));
    chk("halt_rst_active", int'(active), 1);
    step();
    rst_n = 1'b1;

    opcode = OP_RTYPE; function_code = F_DIV;
    step(); step(); step();
    chk("muldiv_entered", int'(state), int'(MULDIV));
    chk("muldiv_busy_on", int'(muldiv_busy), 1);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_state", int'(state), int'(FETCH));
    chk("abort_busy", int'(muldiv_busy), 0);
    chk("abort_active", int'(active), 1);
    chk("abort_hilo", int'({hi_wren, lo_wren}), 0);
    step();
    rst_n = 1'b1;

    run(OP_RTYPE, 6'h21, 5'd0, 1'b0, 1'b0, 0, 0);
    chk("recover_cycles", cyc, 4);
    chk("recover_redir", n_redir, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
